// File: rtl/key_debouncer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : key_debouncer_pkg                                               |
// | Purpose  : Key FSM state encoding, 50 MHz board timing defaults, helpers.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package key_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PRESS_CHK = 2'b01,
        HELD      = 2'b10,
        REL_CHK   = 2'b11
    } key_state_e;

    localparam int unsigned DEF_N_KEYS          = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms @ 50 MHz
    localparam int unsigned DEF_HOLD_CYCLES     = 25_000_000;  // 500 ms @ 50 MHz
    localparam int unsigned DEF_REPEAT_CYCLES   = 5_000_000;   // 100 ms @ 50 MHz

    // Counter width shared by the debounce and hold/repeat counters.
    function automatic int unsigned cnt_width(input int unsigned debounce,
                                              input int unsigned hold);
        int unsigned span;
        span = (debounce > hold) ? debounce : hold;
        return (span == 0) ? 1 : $clog2(span + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_channel.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : key_debounce_channel                                            |
// | Purpose  : One key: 2-flop synchronizer, debounce FSM, hold/repeat timer.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module key_debounce_channel
    import key_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int unsigned CW         = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);
    localparam int unsigned RELOAD_INT = (REPEAT_CYCLES >= HOLD_CYCLES) ? 32'd0
                                                                       : (HOLD_CYCLES - REPEAT_CYCLES);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] RELOAD   = CW'(RELOAD_INT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam bit            REPEAT_EN = (HOLD_CYCLES != 0);

    logic          sync1_q;
    logic          sync2_q;
    logic          pressed;

    key_state_e    state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [CW-1:0] hcnt_q,    hcnt_d;
    logic          level_q,   level_d;
    logic          press_q,   press_d;
    logic          release_q, release_d;
    logic          repeat_q,  repeat_d;

    logic [CW-1:0] hcnt_inc;
    logic          hcnt_wrap;
    logic [CW-1:0] hcnt_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ~sync2_q;

    // The hold timer free-runs through HELD and REL_CHK so a bounce never
    // shifts the repeat cadence; reaching HOLD_MAX reloads one period back.
    assign hcnt_inc  = hcnt_q + 1'b1;
    assign hcnt_wrap = REPEAT_EN && (hcnt_inc == HOLD_MAX);
    assign hcnt_next = !REPEAT_EN ? hcnt_q : (hcnt_wrap ? RELOAD : hcnt_inc);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_CHK: begin
                if (!pressed) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                    press_d = 1'b1;
                    level_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                hcnt_d = hcnt_next;
                if (!pressed) begin
                    state_d = REL_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    repeat_d = hcnt_wrap;
                end
            end
            REL_CHK: begin
                hcnt_d = hcnt_next;
                if (pressed) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= DB_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    hcnt_d    = '0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule
`default_nettype wire

// File: rtl/key_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : key_debouncer                                                   |
// | Purpose  : Active-low KEY pins to debounced level and press/release/repeat |
// |            pulses, one independent channel per key.                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int unsigned N_KEYS          = DEF_N_KEYS,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .key_n_i   (key_n[i]),
            .level_o   (key_level[i]),
            .press_o   (key_press[i]),
            .release_o (key_release[i]),
            .repeat_o  (key_repeat[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_key_debouncer                                                |
// | Purpose  : Directed self-checking bench for key_debouncer (D=4, H=10, R=3) |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_key_debouncer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] key_n = 2'b11;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [1:0] key_repeat;
    logic [7:0] obs;

    int vectors = 0;
    int miscompares = 0;

    key_debouncer #(
        .N_KEYS          (2),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat)
    );

    always #5 clk = ~clk;

    // {level[1:0], press[1:0], release[1:0], repeat[1:0]}
    assign obs = {key_level, key_press, key_release, key_repeat};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        reset_n = 1'b0;
        key_n   = 2'b00;
        repeat (3) tick();
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state got=%b exp=%b", obs, 8'h00);
        end
        reset_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            exp = 8'h00;
            exp[7:6] = (c >= 6 && c < 16) ? 2'b11 : 2'b00;
            exp[5:4] = (c == 6) ? 2'b11 : 2'b00;
            exp[3:2] = (c == 16) ? 2'b11 : 2'b00;
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", c, obs, exp);
            end
            if (c == 10) key_n = 2'b11;
        end
    endtask

    task automatic test_glitch();
        key_n[0] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            vectors++;
            if (obs !== 8'h00) begin
                miscompares++;
                $display("FAIL glitch cyc=%0d got=%b exp=%b", c, obs, 8'h00);
            end
            if (c == 3) key_n[0] = 1'b1;
        end
    endtask

    task automatic test_press_release();
        logic [7:0] exp;
        key_n[0] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            exp = 8'h00;
            exp[6] = (c >= 6 && c < 16);
            exp[4] = (c == 6);
            exp[2] = (c == 16);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL press_release cyc=%0d got=%b exp=%b", c, obs, exp);
            end
            if (c == 10) key_n[0] = 1'b1;
        end
    endtask

    task automatic test_repeat();
        logic [7:0] exp;
        key_n[1] = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            tick();
            exp = 8'h00;
            exp[7] = (c >= 6 && c < 39);
            exp[5] = (c == 6);
            exp[3] = (c == 39);
            exp[1] = (c >= 16 && c <= 34 && ((c - 16) % 3 == 0));
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL repeat cyc=%0d got=%b exp=%b", c, obs, exp);
            end
            if (c == 33) key_n[1] = 1'b1;
        end
    endtask

    task automatic test_bounce();
        logic [7:0] exp;
        key_n[0] = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            tick();
            exp = 8'h00;
            exp[6] = (c >= 6 && c < 32);
            exp[4] = (c == 6);
            exp[2] = (c == 32);
            exp[0] = (c >= 16 && c <= 28 && ((c - 16) % 3 == 0));
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL bounce cyc=%0d got=%b exp=%b", c, obs, exp);
            end
            if (c == 10) key_n[0] = 1'b1;
            if (c == 12) key_n[0] = 1'b0;
            if (c == 26) key_n[0] = 1'b1;
        end
    endtask

    task automatic test_back_to_back_reset();
        logic [7:0] exp;
        key_n[0] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            vectors++;
            if (obs !== 8'h00) begin
                miscompares++;
                $display("FAIL b2b_prechk cyc=%0d got=%b exp=%b", c, obs, 8'h00);
            end
            if (c == 1) key_n[1] = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL b2b_reset_mid got=%b exp=%b", obs, 8'h00);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            exp = 8'h00;
            exp[7:6] = (c >= 6) ? 2'b11 : 2'b00;
            exp[5:4] = (c == 6) ? 2'b11 : 2'b00;
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL b2b_fresh cyc=%0d got=%b exp=%b", c, obs, exp);
            end
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL held_reset_async got=%b exp=%b", obs, 8'h00);
        end
        key_n = 2'b11;
        repeat (2) tick();
        reset_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            vectors++;
            if (obs !== 8'h00) begin
                miscompares++;
                $display("FAIL no_release_after_reset cyc=%0d got=%b exp=%b", c, obs, 8'h00);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press_release();
        test_repeat();
        test_bounce();
        test_back_to_back_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
